squarediff_accum: RTL and testbench
===================================

// Module: squarediff_accum
// PURPOSE
//  Pipelined squared-difference/sum unit with framed accumulation (SSD engine) for DSP-style inference.
//  Per valid sample it computes (a-b)^2 or (a+b)^2 and streams the square out.
//  It also sums the squares over a frame delimited by in_last, publishing the frame total and the sample count.
//  It sits between a sample source (e.g. block-match or error-metric front end) and a score/compare stage.
// PARAMETERS
//  SIZEIN  16  signed width of operands a and b
//  ACCW    48  unsigned width of frame accumulator; must be >= 2*SIZEIN+1
//  CNTW    16  width of frame sample counter
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous, active-high reset
//  clr        in   1            sync flush: kill in-flight samples, restart frame
//  in_valid   in   1            a/b/mode/in_last valid this cycle (no backpressure)
//  in_last    in   1            sample is the last of its frame
//  mode       in   1            0: (a-b)^2, 1: (a+b)^2; sampled per sample
//  a, b       in   SIZEIN       signed operands
//  sq_valid   out  1            sq_out valid
//  sq_out     out  2*SIZEIN+2   signed square (always >= 0)
//  acc_valid  out  1            one-cycle pulse: frame result updated
//  acc_out    out  ACCW         unsigned frame sum (held until next frame completes)
//  acc_count  out  CNTW         samples in published frame (saturating)
//  acc_ovf    out  1            published frame saturated acc or count
// BEHAVIOUR
//  - Reset: all outputs, pipeline valids, running sum/count/ovf = 0.
//  - Stage S1 registers a, b, mode, last, valid.
//  - Stage S2 pre-adds at SIZEIN+1 bits (a-b or a+b) with no wrap; the range is [-2^SIZEIN, 2^SIZEIN-1].
//  - Stage S3 squares it; 2*SIZEIN+2 bits is sufficient; max is 2^(2*SIZEIN) for mode 1 with a=b=-2^(SIZEIN-1).
//  - Latency: sample accepted at edge N -> sq_valid/sq_out after edge N+2 (3 register stages).
//  - sq_valid is exactly in_valid delayed; bubbles propagate and sq_out holds its last value.
//  - Stage S4 accumulates: on S3 valid, run_sum += sq and run_cnt += 1.
//  - Sum saturation: run_sum saturates at 2^ACCW-1 and sets run_ovf.
//  - Count saturation: run_cnt saturates at 2^CNTW-1 and sets run_ovf.
//  - On S3 valid with last: publish acc_out=run_sum+sq (saturated) and acc_count=run_cnt+1 (saturated).
//  - Also publish acc_ovf=run_ovf|new ovf, and pulse acc_valid for 1 cycle.
//  - In the same cycle, run_sum, run_cnt and run_ovf restart at 0.
//  - acc_valid timing: 1 cycle after the matching sq_valid.
//  - Back-to-back frames: the first sample of frame k+1 may follow last of frame k immediately; nothing is lost or merged.
//  - Single-sample frame (valid&last) is legal: count=1.
//  - clr: clears S1-S3 valid bits and run_sum/run_cnt/run_ovf at that edge; published acc_* are retained.
//  - clr priority: clr asserted with in_valid drops that sample, and clr wins over an in-flight last.
//  - rst mid-frame: identical to clr, plus all outputs are zeroed.
//  - in_last without in_valid is ignored.
// TESTING
//  1. SIZEIN=16, mode0, a=5, b=2, valid&last -> sq_out=9 at +3 cycles; acc_valid at +4 with acc_out=9, acc_count=1, acc_ovf=0.
//  2. Frame of 4 with diffs 1,2,3,4 and random bubbles, then back-to-back frame (a=10, b=-10, mode0 with last):
//     -> acc_out=30, count=4, then acc_out=400, count=1; exactly two acc_valid pulses.
//  3. Extremes: mode0 a=-32768, b=32767 -> sq_out=4294836225; mode1 a=b=-32768 -> sq_out=4294967296.
//     The two samples are interleaved on consecutive cycles.
//  4. ACCW=34: 5 samples of 4294967296 (mode1, a=b=-32768), last on the 5th -> acc_out=2^34-1, acc_ovf=1.
//     The next normal frame reports acc_ovf=0.
//  5. clr asserted 1 cycle after a mid-frame sample, with 2 samples in flight:
//     -> no sq_valid or acc contribution from them; the following frame (3,4 diffs) gives acc_out=25.
//     The previous acc_out is held until then.
//  6. rst during an active frame -> all outputs 0 on the next cycle.
//     A fresh frame after rst deasserts sums correctly with acc_count starting at 1.

Source files
------------

// File: rtl/squarediff_accum.sv
// squarediff_accum: pipelined (a-b)^2 / (a+b)^2 engine with framed, saturating
// accumulation of the squares (sum-of-squared-differences unit).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (zeroes pipeline, running state, outputs)
//   clr        synchronous flush: kills in-flight samples and restarts the frame,
//              published acc_* values are retained
//   in_valid   a/b/mode/in_last valid this cycle (no backpressure)
//   in_last    sample closes its frame
//   mode       0: (a-b)^2, 1: (a+b)^2
//   a, b       signed operands, SIZEIN bits
//   sq_valid   sq_out valid (in_valid delayed by three register stages)
//   sq_out     signed square, always >= 0, holds its last value across bubbles
//   acc_valid  one-cycle pulse when a frame result is published
//   acc_out    saturating frame sum of squares
//   acc_count  saturating sample count of the published frame
//   acc_ovf    published frame saturated its sum or its count
module squarediff_accum #(
  parameter int unsigned SIZEIN = 16,
  parameter int unsigned ACCW   = 48,
  parameter int unsigned CNTW   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic                         mode,
  input  logic signed [SIZEIN-1:0]     a,
  input  logic signed [SIZEIN-1:0]     b,
  output logic                         sq_valid,
  output logic signed [2*SIZEIN+1:0]   sq_out,
  output logic                         acc_valid,
  output logic [ACCW-1:0]              acc_out,
  output logic [CNTW-1:0]              acc_count,
  output logic                         acc_ovf
);

  localparam int unsigned DW   = SIZEIN + 1;      // pre-adder width, never wraps
  localparam int unsigned SQW  = 2 * SIZEIN + 2;  // square width
  localparam int unsigned MAGW = 2 * SIZEIN + 1;  // magnitude bits of a non-negative square
  localparam int unsigned SUMW = ACCW + 1;        // accumulator width plus carry

  // S1: operand capture
  logic                     v1, last1, mode1;
  logic signed [SIZEIN-1:0] a1, b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      mode1 <= 1'b0;
      a1    <= '0;
      b1    <= '0;
    end else begin
      v1    <= in_valid & ~clr;
      last1 <= in_last & in_valid;
      mode1 <= mode;
      a1    <= a;
      b1    <= b;
    end
  end

  // S2: sign-extended pre-add/sub
  logic signed [DW-1:0] pre_c;
  logic signed [DW-1:0] d2;
  logic                 v2, last2;

  always_comb begin
    pre_c = '0;
    if (mode1) pre_c = DW'(a1) + DW'(b1);
    else       pre_c = DW'(a1) - DW'(b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      d2    <= '0;
    end else begin
      v2    <= v1 & ~clr;
      last2 <= last1;
      d2    <= pre_c;
    end
  end

  // S3: square; sq_out only updates on valid data so bubbles hold the last value
  logic signed [SQW-1:0] dx_c;
  logic signed [SQW-1:0] sq_c;
  logic                  last3;

  always_comb begin
    dx_c = SQW'(d2);
    sq_c = dx_c * dx_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_valid <= 1'b0;
      sq_out   <= '0;
      last3    <= 1'b0;
    end else begin
      sq_valid <= v2 & ~clr;
      last3    <= last2;
      if (v2 & ~clr) sq_out <= sq_c;
    end
  end

  // S4: saturating running sum/count for the open frame
  logic [ACCW-1:0] run_sum;
  logic [CNTW-1:0] run_cnt;
  logic            run_ovf;

  logic [SUMW-1:0] sum_c;
  logic            sum_sat_c;
  logic [ACCW-1:0] sum_next_c;
  logic            cnt_sat_c;
  logic [CNTW-1:0] cnt_next_c;
  logic            ovf_next_c;

  always_comb begin
    sum_c      = {1'b0, run_sum} + SUMW'(sq_out[MAGW-1:0]);
    sum_sat_c  = sum_c[SUMW-1];
    sum_next_c = sum_sat_c ? '1 : sum_c[ACCW-1:0];
    cnt_sat_c  = &run_cnt;
    cnt_next_c = cnt_sat_c ? run_cnt : run_cnt + CNTW'(1);
    ovf_next_c = run_ovf | sum_sat_c | cnt_sat_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_sum   <= '0;
      run_cnt   <= '0;
      run_ovf   <= 1'b0;
      acc_valid <= 1'b0;
      acc_out   <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else if (clr) begin
      // flush wins over an in-flight last; published results stay visible
      run_sum   <= '0;
      run_cnt   <= '0;
      run_ovf   <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= sq_valid & last3;
      if (sq_valid) begin
        if (last3) begin
          acc_out   <= sum_next_c;
          acc_count <= cnt_next_c;
          acc_ovf   <= ovf_next_c;
          run_sum   <= '0;
          run_cnt   <= '0;
          run_ovf   <= 1'b0;
        end else begin
          run_sum   <= sum_next_c;
          run_cnt   <= cnt_next_c;
          run_ovf   <= ovf_next_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_squarediff_accum.sv
// Directed bench for squarediff_accum: two instances share stimulus, one with the
// default 48-bit accumulator and one with a 34-bit accumulator to reach saturation.
module tb_squarediff_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic mode = 1'b0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;

  logic               sq_valid_a, acc_valid_a, acc_ovf_a;
  logic signed [33:0] sq_out_a;
  logic [47:0]        acc_out_a;
  logic [15:0]        acc_count_a;

  logic               sq_valid_b, acc_valid_b, acc_ovf_b;
  logic signed [33:0] sq_out_b;
  logic [33:0]        acc_out_b;
  logic [15:0]        acc_count_b;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  squarediff_accum #(.SIZEIN(16), .ACCW(48), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_last(in_last),
    .mode(mode), .a(a), .b(b),
    .sq_valid(sq_valid_a), .sq_out(sq_out_a), .acc_valid(acc_valid_a),
    .acc_out(acc_out_a), .acc_count(acc_count_a), .acc_ovf(acc_ovf_a)
  );

  squarediff_accum #(.SIZEIN(16), .ACCW(34), .CNTW(16)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_last(in_last),
    .mode(mode), .a(a), .b(b),
    .sq_valid(sq_valid_b), .sq_out(sq_out_b), .acc_valid(acc_valid_b),
    .acc_out(acc_out_b), .acc_count(acc_count_b), .acc_ovf(acc_ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (acc_valid_a) pulses++;
  endtask

  task automatic send(input logic m, input int ai, input int bi, input logic l);
    in_valid = 1'b1;
    in_last  = l;
    mode     = m;
    a        = 16'(ai);
    b        = 16'(bi);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
  endtask

  initial begin
    // reset
    step();
    step();
    chk("rst_sq_valid", 64'(sq_valid_a), 64'd0);
    chk("rst_sq_out", 64'(sq_out_a), 64'd0);
    chk("rst_acc_valid", 64'(acc_valid_a), 64'd0);
    chk("rst_acc_out", 64'(acc_out_a), 64'd0);
    chk("rst_acc_count", 64'(acc_count_a), 64'd0);
    chk("rst_acc_ovf", 64'(acc_ovf_a), 64'd0);
    rst = 1'b0;
    step();

    // single-sample frame: (5-2)^2 = 9
    send(1'b0, 5, 2, 1'b1);
    idle();
    chk("t1_sq_valid_early", 64'(sq_valid_a), 64'd0);
    idle();
    chk("t1_sq_valid", 64'(sq_valid_a), 64'd1);
    chk("t1_sq_out", 64'(sq_out_a), 64'd9);
    chk("t1_acc_valid_early", 64'(acc_valid_a), 64'd0);
    idle();
    chk("t1_acc_valid", 64'(acc_valid_a), 64'd1);
    chk("t1_acc_out", 64'(acc_out_a), 64'd9);
    chk("t1_acc_count", 64'(acc_count_a), 64'd1);
    chk("t1_acc_ovf", 64'(acc_ovf_a), 64'd0);
    idle();
    chk("t1_acc_pulse_end", 64'(acc_valid_a), 64'd0);
    chk("t1_sq_hold", 64'(sq_out_a), 64'd9);

    // frame of diffs 1,2,-3,4 with bubbles, then a back-to-back 1-sample frame
    pulses = 0;
    send(1'b0, 1, 0, 1'b0);
    idle();
    send(1'b0, 5, 3, 1'b0);
    idle();
    idle();
    send(1'b0, 0, 3, 1'b0);
    send(1'b0, 6, 2, 1'b1);
    send(1'b0, 10, -10, 1'b1);
    idle();
    idle();
    chk("t2_acc_valid_f1", 64'(acc_valid_a), 64'd1);
    chk("t2_acc_out_f1", 64'(acc_out_a), 64'd30);
    chk("t2_acc_count_f1", 64'(acc_count_a), 64'd4);
    idle();
    chk("t2_acc_valid_f2", 64'(acc_valid_a), 64'd1);
    chk("t2_acc_out_f2", 64'(acc_out_a), 64'd400);
    chk("t2_acc_count_f2", 64'(acc_count_a), 64'd1);
    idle();
    chk("t2_acc_valid_end", 64'(acc_valid_a), 64'd0);
    chk("t2_pulses", 64'(pulses), 64'd2);

    // operand extremes on consecutive cycles
    send(1'b0, -32768, 32767, 1'b0);
    send(1'b1, -32768, -32768, 1'b0);
    idle();
    chk("t3_sq_max_diff", 64'(sq_out_a), 64'd4294836225);
    idle();
    chk("t3_sq_max_sum", 64'(sq_out_a), 64'd4294967296);
    chk("t3_sq_valid", 64'(sq_valid_a), 64'd1);
    in_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_clr_acc_hold", 64'(acc_out_a), 64'd400);
    chk("t3_clr_acc_valid", 64'(acc_valid_a), 64'd0);

    // clr with two samples in flight plus one presented alongside it
    send(1'b0, 10, 9, 1'b0);
    send(1'b0, 12, 10, 1'b0);
    in_valid = 1'b1;
    a = 16'sd9;
    b = 16'sd0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_killed_0", 64'(sq_valid_a), 64'd0);
    idle();
    chk("t5_killed_1", 64'(sq_valid_a), 64'd0);
    idle();
    chk("t5_killed_2", 64'(sq_valid_a), 64'd0);
    chk("t5_acc_hold", 64'(acc_out_a), 64'd400);
    idle();
    chk("t5_no_acc_valid", 64'(acc_valid_a), 64'd0);
    send(1'b0, 3, 0, 1'b0);
    send(1'b0, 0, 4, 1'b1);
    idle();
    idle();
    chk("t5_acc_hold_late", 64'(acc_out_a), 64'd400);
    idle();
    chk("t5_acc_valid", 64'(acc_valid_a), 64'd1);
    chk("t5_acc_out", 64'(acc_out_a), 64'd25);
    chk("t5_acc_count", 64'(acc_count_a), 64'd2);

    // sum saturation on the 34-bit instance: 5 * 2^32 > 2^34-1
    for (int i = 0; i < 5; i++) send(1'b1, -32768, -32768, (i == 4));
    idle();
    idle();
    idle();
    chk("t4_b_acc_valid", 64'(acc_valid_b), 64'd1);
    chk("t4_b_acc_out", 64'(acc_out_b), 64'd17179869183);
    chk("t4_b_acc_count", 64'(acc_count_b), 64'd5);
    chk("t4_b_acc_ovf", 64'(acc_ovf_b), 64'd1);
    chk("t4_a_acc_out", 64'(acc_out_a), 64'd21474836480);
    chk("t4_a_acc_ovf", 64'(acc_ovf_a), 64'd0);
    send(1'b0, 5, 2, 1'b1);
    idle();
    idle();
    idle();
    chk("t4_b_next_out", 64'(acc_out_b), 64'd9);
    chk("t4_b_next_ovf", 64'(acc_ovf_b), 64'd0);
    chk("t4_b_next_count", 64'(acc_count_b), 64'd1);

    // rst during an open frame
    send(1'b0, 1, 0, 1'b0);
    send(1'b0, 2, 0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_sq_out", 64'(sq_out_a), 64'd0);
    chk("t6_sq_valid", 64'(sq_valid_a), 64'd0);
    chk("t6_acc_out", 64'(acc_out_a), 64'd0);
    chk("t6_acc_count", 64'(acc_count_a), 64'd0);
    chk("t6_b_acc_out", 64'(acc_out_b), 64'd0);
    idle();
    chk("t6_flushed", 64'(sq_valid_a), 64'd0);
    send(1'b0, 4, 1, 1'b1);
    idle();
    idle();
    idle();
    chk("t6_acc_valid", 64'(acc_valid_a), 64'd1);
    chk("t6_acc_out_fresh", 64'(acc_out_a), 64'd9);
    chk("t6_acc_count_fresh", 64'(acc_count_a), 64'd1);
    chk("t6_acc_ovf_fresh", 64'(acc_ovf_a), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
